// File: rtl/mbt_pkg.sv
// rtl/mbt_pkg.sv - shared constants and FSM encoding for the MBT dispatch sequencer
package mbt_pkg;

   localparam int MBT_LANES       = 4;
   localparam int MBT_ITER_W      = 8;
   localparam int MBT_ADDR_W      = 19;
   localparam int MBT_H_RES       = 800;
   localparam int MBT_V_RES       = 600;
   localparam int MBT_PARAM_LAT   = 3;
   localparam int MBT_TIMEOUT_CYC = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SETUP,
      S_START,
      S_WAIT,
      S_WRITE,
      S_ADV,
      S_DONE
   } mbt_state_t;

endpackage

// File: rtl/mbt_done_collect.sv
// rtl/mbt_done_collect.sv - sticky per-lane done flags, iteration capture and group-complete detect
// MBT_TIMEOUT_EN adds a WAIT watchdog; unfinished lanes then report all-ones.
module mbt_done_collect
   import mbt_pkg::*;
#(
   parameter int LANES  = MBT_LANES,
   parameter int ITER_W = MBT_ITER_W
`ifdef MBT_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = MBT_TIMEOUT_CYC
`endif
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      en,
   input  logic [LANES-1:0]          mbt_done,
   input  logic [LANES*ITER_W-1:0]   mbt_iter,
   output logic                      go,
   output logic [LANES*ITER_W-1:0]   lane_data
);

   logic [LANES-1:0]        sticky_q, sticky_d;
   logic [LANES*ITER_W-1:0] hold_q, hold_d;

   // Capture a lane's count only on the first cycle its done bit is seen.
   always_comb begin
      sticky_d = sticky_q;
      hold_d   = hold_q;
      if (clr) begin
         sticky_d = '0;
         hold_d   = '0;
      end else if (en) begin
         sticky_d = sticky_q | mbt_done;
         for (int k = 0; k < LANES; k++) begin
            if (mbt_done[k] && !sticky_q[k]) begin
               hold_d[k*ITER_W +: ITER_W] = mbt_iter[k*ITER_W +: ITER_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
         hold_q   <= '0;
      end else begin
         sticky_q <= sticky_d;
         hold_q   <= hold_d;
      end
   end

`ifdef MBT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             timed_out;

   always_comb begin
      tmo_d     = en ? tmo_q + TMO_W'(1) : '0;
      timed_out = en && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
      go        = en && ((&sticky_d) || timed_out);
      lane_data = hold_d;
      for (int k = 0; k < LANES; k++) begin
         if (!sticky_d[k]) begin
            lane_data[k*ITER_W +: ITER_W] = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   always_comb begin
      go        = en && (&sticky_d);
      lane_data = hold_d;
   end
`endif

endmodule

// File: rtl/mbt_dispatch.sv
// rtl/mbt_dispatch.sv - raster frame-scan sequencer driving MBT engines and frame-buffer writes
// MBT_TIMEOUT_EN enables the WAIT-state watchdog (TIMEOUT_CYC).
module mbt_dispatch
   import mbt_pkg::*;
#(
   parameter int H_RES     = MBT_H_RES,
   parameter int V_RES     = MBT_V_RES,
   parameter int LANES     = MBT_LANES,
   parameter int ITER_W    = MBT_ITER_W,
   parameter int ADDR_W    = MBT_ADDR_W,
   parameter int PARAM_LAT = MBT_PARAM_LAT
`ifdef MBT_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = MBT_TIMEOUT_CYC
`endif
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_go,
   output logic [15:0]             i_x,
   output logic [15:0]             i_y,
   output logic                    rstMBT,
   output logic                    start,
   input  logic [LANES-1:0]        mbt_done,
   input  logic [LANES*ITER_W-1:0] mbt_iter,
   output logic                    fb_we,
   output logic [ADDR_W-1:0]       fb_addr,
   output logic [ITER_W-1:0]       fb_data,
   output logic                    frame_busy,
   output logic                    frame_done
);

   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = 8;

   mbt_state_t          state_q, state_d;
   logic [15:0]         x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]   row_base_q, row_base_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rst_mbt_q, rst_mbt_d, start_q, start_d;
   logic                fb_we_q, fb_we_d, busy_q, busy_d, fdone_q, fdone_d;
   logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
   logic [ITER_W-1:0]   fb_data_q, fb_data_d;
   logic [LANE_W-1:0]   lane_d;
   logic                collect_clr, collect_en, group_go;
   logic [LANES*ITER_W-1:0] lane_data;

   assign collect_clr = (state_q == S_RST);
   assign collect_en  = (state_q == S_WAIT);

   mbt_done_collect #(
      .LANES       (LANES),
      .ITER_W      (ITER_W)
`ifdef MBT_TIMEOUT_EN
      , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
   ) u_collect (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (collect_clr),
      .en        (collect_en),
      .mbt_done  (mbt_done),
      .mbt_iter  (mbt_iter),
      .go        (group_go),
      .lane_data (lane_data)
   );

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      row_base_d = row_base_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_IDLE: if (frame_go) begin
            x_d        = '0;
            y_d        = '0;
            row_base_d = '0;
            state_d    = S_RST;
         end
         S_RST: begin
            cnt_d   = '0;
            state_d = S_SETUP;
         end
         S_SETUP: if (cnt_q == CNT_W'(PARAM_LAT - 1)) state_d = S_START;
                  else cnt_d = cnt_q + CNT_W'(1);
         S_START: state_d = S_WAIT;
         S_WAIT: if (group_go) begin
            cnt_d   = '0;
            state_d = S_WRITE;
         end
         S_WRITE: if (cnt_q == CNT_W'(LANES - 1)) state_d = S_ADV;
                  else cnt_d = cnt_q + CNT_W'(1);
         S_ADV: begin
            // Row wrap advances the base by a whole row; no multiplier needed.
            if (x_q == 16'(H_RES - LANES)) begin
               x_d        = '0;
               y_d        = y_q + 16'd1;
               row_base_d = row_base_q + ADDR_W'(H_RES);
            end else begin
               x_d = x_q + 16'(LANES);
            end
            if (y_q == 16'(V_RES - 1) && x_q == 16'(H_RES - LANES)) state_d = S_DONE;
            else state_d = S_RST;
         end
         S_DONE: state_d = S_IDLE;
      endcase

      lane_d    = cnt_d[LANE_W-1:0];
      rst_mbt_d = (state_d == S_RST);
      start_d   = (state_d == S_START);
      fb_we_d   = (state_d == S_WRITE);
      busy_d    = (state_d != S_IDLE);
      fdone_d   = (state_d == S_DONE);
      fb_addr_d = fb_we_d ? row_base_d + ADDR_W'(x_d) + ADDR_W'(lane_d) : '0;
      fb_data_d = fb_we_d ? lane_data[int'(lane_d)*ITER_W +: ITER_W] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         row_base_q <= '0;
         cnt_q      <= '0;
         rst_mbt_q  <= 1'b0;
         start_q    <= 1'b0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         busy_q     <= 1'b0;
         fdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         row_base_q <= row_base_d;
         cnt_q      <= cnt_d;
         rst_mbt_q  <= rst_mbt_d;
         start_q    <= start_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         busy_q     <= busy_d;
         fdone_q    <= fdone_d;
      end
   end

   assign i_x        = x_q;
   assign i_y        = y_q;
   assign rstMBT     = rst_mbt_q;
   assign start      = start_q;
   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign frame_busy = busy_q;
   assign frame_done = fdone_q;

endmodule

// File: doc/mbt_dispatch.md
Name: mbt_dispatch

Overview:
- Frame-scan sequencer that drives the pixel side of the coordinate-fetch stage and collects results from the four MBT engines it feeds.
- Issues i_x/i_y in steps of LANES columns, raster order.
- Sequences rstMBT/start, waits for all lane done flags, then writes the four iteration counts to the frame buffer.
- Sits between the top-level frame control and the fetch/MBT/frame-buffer datapath.

Parameters:
- H_RES, 800, pixels per row; must be a multiple of LANES.
- V_RES, 600, rows per frame.
- LANES, 4, number of MBT engines; fixed at 4 in this release.
- ITER_W, 8, iteration count width.
- ADDR_W, 19, frame-buffer address width.
- PARAM_LAT, 3, cycles coordinates are held stable before start, covering the fetch-stage register depth.
- TIMEOUT_CYC, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_go  in  1  one-cycle request to render a frame
- i_x  out  16  current column, lane 0 of the group
- i_y  out  16  current row
- rstMBT  out  1  one-cycle MBT engine reset
- start  out  1  one-cycle MBT start
- mbt_done  in  LANES  per-lane done level; held until the next rstMBT
- mbt_iter  in  LANES*ITER_W  per-lane iteration count; lane k at bits [k*ITER_W +: ITER_W]; valid while its done bit is high
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  ADDR_W  write address
- fb_data  out  ITER_W  write data
- frame_busy  out  1  high from frame acceptance until DONE exits
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async assert, sync release): state IDLE. i_x, i_y, rstMBT, start, fb_we, fb_addr, fb_data, frame_busy, frame_done and all counters and sticky flags are 0.
- FSM: IDLE -> RST -> SETUP -> START -> WAIT -> WRITE -> ADV -> (RST | DONE) -> IDLE.
- IDLE: frame_go=1 clears x, y and row_base to 0, sets frame_busy, and moves to RST. frame_go is ignored in every other state.
- RST: rstMBT=1 for one cycle. Clears the sticky done vector. Goes to SETUP.
- SETUP: i_x/i_y are stable. Counts PARAM_LAT cycles, then goes to START.
- START: start=1 for one cycle. Goes to WAIT.
- WAIT: sticky[k] |= mbt_done[k] every cycle, and lane k's mbt_iter is captured into a hold register on the first cycle its done bit is seen. Done bits may arrive in any order and any cycle. Leaves for WRITE the cycle after sticky becomes all ones.
- WRITE: LANES consecutive cycles with fb_we=1, lane k=0..3. fb_addr = row_base + x + k. fb_data = held iter[k]. No stalls; the frame buffer always accepts.
- ADV: x += LANES. If x+LANES == H_RES: x=0, y+=1, row_base += H_RES. If that was the last group (y == V_RES-1 and x == H_RES-LANES), go to DONE; otherwise go to RST.
- DONE: frame_done=1 for one cycle, frame_busy drops to 0 on exit, goes to IDLE. frame_done and a later frame_go never overlap.
- Address arithmetic: row_base is an accumulator; no multiplier. All address math is unsigned ADDR_W. Last address = H_RES*V_RES-1 (479999 by default; fits in 19 bits).
- i_x/i_y are zero-extended unsigned integers to 16 bits.
- Per-group cycle count: 1 + PARAM_LAT + 1 + wait + LANES + 1.
- Reset mid-frame: returns immediately to IDLE with all outputs 0. The partial frame is abandoned; no frame_done.

Optional Feature:
- Macro: MBT_TIMEOUT_EN.
- Defined: a WAIT-state counter, cleared on WAIT entry. When it reaches TIMEOUT_CYC, the FSM goes to WRITE. Lanes whose sticky bit is 0 are written with all-ones ({ITER_W{1'b1}}, treated as in-set). Lanes that completed are written with their captured value.
- Undefined: WAIT waits indefinitely; no counter logic is present.

Decomposition:
- Shared package mbt_pkg: state encoding localparams, LANES, ITER_W, default H_RES/V_RES, ADDR_W.
- One natural sub-module: mbt_done_collect, holding the sticky done vector, per-lane iter capture and the all-done flag (plus the timeout counter when MBT_TIMEOUT_EN is defined).
- FSM, x/y counters and address generation stay in the top module.

Test Plan:
- H_RES=8, V_RES=2, all lanes done 5 cycles after start -> 16 writes, addrs 0..15 in order, data = driven iters, exactly 4 rstMBT/start pulses, one frame_done, i_x sequence 0,4,0,4 with i_y 0,0,1,1.
- Done order lane3, lane0, lane2, lane1 with 3-cycle gaps -> WRITE begins the cycle after lane1 done; data in lane order 0..3.
- frame_go pulsed during WAIT -> ignored; the frame completes with 16 writes; frame_done count = 1.
- rst_n asserted mid-WAIT of group 2 -> all outputs 0 in the same cycle; a new frame_go restarts at addr 0.
- Check start timing -> start rises exactly PARAM_LAT+1 cycles after rstMBT; i_x/i_y unchanged from RST through WAIT.
- With MBT_TIMEOUT_EN, TIMEOUT_CYC=16, lane2 never done -> WRITE 16 cycles after WAIT entry; lane2 written 0xFF, other lanes their values.
